// File: rtl/ptcalc_mul_pipe.sv
// ptcalc_mul_pipe
// Pipelined unsigned-by-signed multiplier with lock-step valid/ready flow
// control, optional multiply-accumulate and a saturating signed result.
//
// Ports:
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous active-high reset
//   in_valid   in   input beat present
//   in_ready   out  beat accepted when in_valid & in_ready (= advance enable)
//   din0       in   A_WIDTH unsigned multiplicand
//   din1       in   B_WIDTH signed multiplier
//   acc_en     in   beat adds its product to the accumulator
//   acc_clr    in   with acc_en: accumulator restarts from zero for this beat
//   out_valid  out  result beat present
//   out_ready  in   consumer accepts when out_valid & out_ready
//   dout       out  P_WIDTH signed (saturated) result
//   ovf        out  result of this beat was clamped
//
// The pipeline holds NUM_STAGE registers in total: NUM_STAGE-1 product
// stages followed by the output register, where accumulation and saturation
// happen. A beat presented in cycle c is visible at the output in cycle
// c+NUM_STAGE while the pipeline keeps advancing.

module ptcalc_mul_pipe #(
   parameter int A_WIDTH   = 26,
   parameter int B_WIDTH   = 16,
   parameter int P_WIDTH   = 42,
   parameter int NUM_STAGE = 3
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [A_WIDTH-1:0]        din0,
   input  logic signed [B_WIDTH-1:0] din1,
   input  logic                      acc_en,
   input  logic                      acc_clr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [P_WIDTH-1:0] dout,
   output logic                      ovf
);

   // Product is carried one bit wider than strictly needed so both operands
   // can be extended to the same width without a truncation step.
   localparam int PROD_W = A_WIDTH + B_WIDTH + 1;
   // Accumulate adder: wide enough that acc + product can never wrap.
   localparam int SUM_W  = ((P_WIDTH > PROD_W) ? P_WIDTH : PROD_W) + 1;
   // Bits that must all equal the sign bit for the sum to fit in P_WIDTH.
   localparam int HI_W   = SUM_W - P_WIDTH + 1;

   // Saturate a SUM_W two's-complement value to P_WIDTH.
   // Returns {clamped, value}.
   function automatic logic [P_WIDTH:0] sat_fn(input logic [SUM_W-1:0] x);
      logic [HI_W-1:0] hi;
      logic [P_WIDTH:0] res;
      hi = x[SUM_W-1:P_WIDTH-1];
      if ((hi == {HI_W{1'b0}}) || (hi == {HI_W{1'b1}})) begin
         res = {1'b0, x[P_WIDTH-1:0]};
      end else if (x[SUM_W-1] == 1'b0) begin
         res = {1'b1, 1'b0, {(P_WIDTH-1){1'b1}}};
      end else begin
         res = {1'b1, 1'b1, {(P_WIDTH-1){1'b0}}};
      end
      return res;
   endfunction

   logic                 adv_s;
   logic [PROD_W-1:0]    a_ext_s;
   logic [PROD_W-1:0]    b_ext_s;
   logic [PROD_W-1:0]    prod_in_s;

   logic                 fin_valid_s;
   logic                 fin_acc_en_s;
   logic                 fin_acc_clr_s;
   logic [PROD_W-1:0]    fin_prod_s;

   logic                 out_valid_q, out_valid_d;
   logic [P_WIDTH-1:0]   dout_q, dout_d;
   logic                 ovf_q, ovf_d;
   logic [P_WIDTH-1:0]   acc_q, acc_d;

   logic [SUM_W-1:0]     acc_x_s;
   logic [SUM_W-1:0]     prod_x_s;
   logic [SUM_W-1:0]     sum_s;
   logic [P_WIDTH:0]     sat_s;

   // Whole pipeline moves together unless a result is waiting to be taken.
   assign adv_s    = ~out_valid_q | out_ready;
   assign in_ready = adv_s;

   // Zero-extend din0 (unsigned) and sign-extend din1. With both operands at
   // the full product width, the low PROD_W bits of a plain multiply are the
   // exact two's-complement product.
   assign a_ext_s   = {{(B_WIDTH+1){1'b0}}, din0};
   assign b_ext_s   = {{(A_WIDTH+1){din1[B_WIDTH-1]}}, din1};
   assign prod_in_s = a_ext_s * b_ext_s;

   generate
      if (NUM_STAGE == 1) begin : g_direct
         assign fin_valid_s   = in_valid;
         assign fin_acc_en_s  = acc_en;
         assign fin_acc_clr_s = acc_clr;
         assign fin_prod_s    = prod_in_s;
      end else begin : g_stages
         localparam int D = NUM_STAGE - 1;
         logic [D-1:0]      vld_q;
         logic [D-1:0]      ae_q;
         logic [D-1:0]      ac_q;
         logic [PROD_W-1:0] prod_q [D];

         // Product shift stages; bubbles are held in place just like beats.
         always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
               vld_q <= {D{1'b0}};
               ae_q  <= {D{1'b0}};
               ac_q  <= {D{1'b0}};
               for (int i = 0; i < D; i++) begin
                  prod_q[i] <= {PROD_W{1'b0}};
               end
            end else if (adv_s) begin
               vld_q[0]  <= in_valid;
               ae_q[0]   <= acc_en;
               ac_q[0]   <= acc_clr;
               prod_q[0] <= prod_in_s;
               for (int i = 1; i < D; i++) begin
                  vld_q[i]  <= vld_q[i-1];
                  ae_q[i]   <= ae_q[i-1];
                  ac_q[i]   <= ac_q[i-1];
                  prod_q[i] <= prod_q[i-1];
               end
            end
         end

         assign fin_valid_s   = vld_q[D-1];
         assign fin_acc_en_s  = ae_q[D-1];
         assign fin_acc_clr_s = ac_q[D-1];
         assign fin_prod_s    = prod_q[D-1];
      end
   endgenerate

   assign acc_x_s  = {{(SUM_W-P_WIDTH){acc_q[P_WIDTH-1]}}, acc_q};
   assign prod_x_s = {{(SUM_W-PROD_W){fin_prod_s[PROD_W-1]}}, fin_prod_s};

   // Output-stage next state: optional accumulate, saturate, hold on stall.
   always_comb begin
      sum_s       = prod_x_s;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      ovf_d       = ovf_q;
      acc_d       = acc_q;
      // acc_clr only matters together with acc_en; clr restarts from zero.
      if (fin_acc_en_s && !fin_acc_clr_s) begin
         sum_s = acc_x_s + prod_x_s;
      end else begin
         sum_s = prod_x_s;
      end
      sat_s = sat_fn(sum_s);
      if (adv_s) begin
         out_valid_d = fin_valid_s;
         if (fin_valid_s) begin
            dout_d = sat_s[P_WIDTH-1:0];
            ovf_d  = sat_s[P_WIDTH];
            if (fin_acc_en_s) begin
               acc_d = sat_s[P_WIDTH-1:0];
            end else begin
               acc_d = acc_q;
            end
         end else begin
            // Bubble: only out_valid drops, data and ovf keep their values.
            dout_d = dout_q;
            ovf_d  = ovf_q;
            acc_d  = acc_q;
         end
      end else begin
         out_valid_d = out_valid_q;
         dout_d      = dout_q;
         ovf_d       = ovf_q;
         acc_d       = acc_q;
      end
   end

   // Output register and accumulator.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_valid_q <= 1'b0;
         dout_q      <= {P_WIDTH{1'b0}};
         ovf_q       <= 1'b0;
         acc_q       <= {P_WIDTH{1'b0}};
      end else begin
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         ovf_q       <= ovf_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/ptcalc_mul_pipe.md
# ptcalc_mul_pipe

Parametrised, pipelined unsigned-by-signed multiplier with valid/ready flow control, optional multiply-accumulate mode and saturating output. It is the general successor to the fixed-width, single-stage multiplier instances generated for the ptcalc datapath. Typical uses are the pT-calculation polynomial and sagitta products, where throughput must be held under downstream backpressure. Width, depth and accumulate behaviour are set per instance, so one block serves every product in ptcalc_top.

## Interface
Parameters:
- A_WIDTH, 26, width of unsigned operand din0 (>=2)
- B_WIDTH, 16, width of signed operand din1 (>=2)
- P_WIDTH, 42, width of signed result/accumulator (>=A_WIDTH+B_WIDTH recommended; smaller allowed, saturates)
- NUM_STAGE, 3, pipeline depth in cycles from accepted input to out_valid (>=1)

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat when in_valid & in_ready
- din0  in  A_WIDTH  unsigned multiplicand
- din1  in  B_WIDTH  signed (two's complement) multiplier
- acc_en  in  1  beat adds product to accumulator
- acc_clr  in  1  with acc_en: accumulator restarts from 0 for this beat
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts when out_valid & out_ready
- dout  out  P_WIDTH  signed result
- ovf  out  1  result of this beat was saturated

## Operation
- Full product: signed({1'b0,din0}) * signed(din1), exact, A_WIDTH+B_WIDTH bits.
- Pipeline is a lock-step shift of NUM_STAGE registers, each carrying valid, product/operands, acc_en, acc_clr.
- Global advance enable: adv = ~out_valid | out_ready. When adv=0, every stage holds, bubbles included; no compaction.
- in_ready = adv (combinational from out_valid, out_ready). in_valid must not depend on in_ready.
- Final stage load (adv=1, valid beat entering output register):
  - acc_en=0: dout = sat(product); accumulator unchanged.
  - acc_en=1, acc_clr=1: dout = sat(product); acc <= dout.
  - acc_en=1, acc_clr=0: dout = sat(acc + product); acc <= dout.
  - acc_clr without acc_en is ignored.
- Sum is computed at P_WIDTH+max(0,A_WIDTH+B_WIDTH-P_WIDTH)+1 bits before saturation; no wrap ever.
- sat(x) clamps to [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1]. ovf=1 iff a clamp occurred on that beat. ovf is not sticky.
- Accumulator saturates (holds the clamped value); it is not cleared by bubbles.
- Bubble entering output register (adv=1): out_valid<=0; dout, ovf hold their last values.

## Timing
- Reset (ap_rst=1 at edge):
  - all stage valids, out_valid, dout, ovf, accumulator <= 0.
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are dropped; no out_valid pulse follows.
- Latency: beat accepted at edge k appears with out_valid=1 after edge k+NUM_STAGE, provided adv=1 throughout.
- Throughput: 1 beat/cycle while out_ready=1.
- out_valid=1 & out_ready=0: dout, ovf, out_valid are held stable until accepted.
- Simultaneous accept and load: output register is replaced on the same edge; no bubble inserted.
- Maximum in-flight beats = NUM_STAGE, plus none buffered beyond that.
- NUM_STAGE=1: the product and accumulate complete in the single output register.

## Test plan
- Latency, NUM_STAGE=3: din0=1000, din1=-3 accepted at cycle 0, out_ready=1 -> out_valid at cycle 3, dout=-3000, ovf=0.
- Extremes, default widths: din0=67108863, din1=-32768 -> dout=-2199023222784, ovf=0. din0=0, din1=-1 -> dout=0.
- Accumulate with saturation, default widths: beat1 as above with acc_en=1, acc_clr=1 -> dout=-2199023222784. Beat2 identical with acc_clr=0 -> dout=-2199023255552, ovf=1. Beat3: din0=1, din1=5, acc_en=1 -> dout=-2199023255547, ovf=0.
- Backpressure: stream 8 beats (din0=i, din1=2); hold out_ready=0 for cycles 2-7. Expect in_ready=0 while the pipeline is full and out_valid is held, dout stable. After release, outputs 0,2,4,...,14 in order with no loss or duplication.
- Reset mid-stream: assert ap_rst for 1 cycle with 3 beats in flight. Expect out_valid=0, dout=0, in_ready=1 next cycle, no stale outputs, and the accumulator back at 0.
- Narrow instance, A_WIDTH=8, B_WIDTH=8, P_WIDTH=12, NUM_STAGE=1: 255*127 -> dout=2047, ovf=1. 255*-128 -> dout=-2048, ovf=1. Both appear one cycle after accept.
